// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl: auto/manual step sequencer, match counter and halt control for the sequence detector
module seq_step_ctrl #(
    parameter int DIV         = 12500000,
    parameter int CNT_W       = 4,
    parameter int MAX_MATCHES = 9,
    parameter int HOLD_STEPS  = 4
) (
    input  logic             i_clock_50,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_step_key,
    input  logic             i_bit_in,
    input  logic             i_clear,
    input  logic             i_match,
    output logic             o_det_step,
    output logic             o_det_bit,
    output logic             o_det_clr,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_match_led,
    output logic             o_halted,
    output logic [1:0]       o_state_out
);
    localparam int PW = $clog2(DIV);
    localparam int HW = $clog2(HOLD_STEPS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, AUTO = 2'd1, MANUAL = 2'd2, HALT = 2'd3} state_t;

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_presc, w_presc_nxt;
    logic [HW-1:0]    r_hold, w_hold_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_bit_s1, r_bit_s, r_key_s1, r_key_s, r_key_q;
    logic             r_step, r_step_q, r_clr, r_bit, r_led, r_halted;
    logic             w_key_edge, w_tick, w_samp, w_hit, w_step_nxt, w_clr_nxt;

    // r_step_q marks the cycle the detector's match output reflects the last step
    always_comb begin
        w_key_edge  = r_key_s & ~r_key_q;
        w_tick      = (r_state == AUTO) && (r_presc == PW'(DIV - 1));
        w_samp      = r_step_q & i_match;
        w_cnt_inc   = r_cnt + 1'b1;
        w_hit       = w_samp && (w_cnt_inc == CNT_W'(MAX_MATCHES));
        w_state_nxt = r_state;
        w_step_nxt  = 1'b0;
        w_clr_nxt   = 1'b0;
        if (i_clear) begin
            w_state_nxt = IDLE;
            w_clr_nxt   = 1'b1;
        end else if (w_hit) begin
            w_state_nxt = HALT;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = i_start ? (i_mode ? AUTO : MANUAL) : IDLE;
                    w_clr_nxt   = i_start;
                end
                AUTO: begin
                    w_state_nxt = i_mode ? AUTO : MANUAL;
                    w_step_nxt  = i_mode & w_tick;
                end
                MANUAL: begin
                    w_state_nxt = i_mode ? AUTO : MANUAL;
                    w_step_nxt  = ~i_mode & w_key_edge;
                end
                default: w_state_nxt = HALT;
            endcase
        end
        w_presc_nxt = (r_state == AUTO && w_state_nxt == AUTO && !w_tick) ? r_presc + 1'b1 : '0;
        w_cnt_nxt   = i_clear ? '0 : (w_samp ? w_cnt_inc : r_cnt);
        w_hold_nxt  = i_clear ? '0 : w_samp ? HW'(HOLD_STEPS) :
                      (r_step && r_hold != '0) ? r_hold - 1'b1 : r_hold;
    end

    always_ff @(posedge i_clock_50) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_presc  <= '0;
            r_hold   <= '0;
            r_cnt    <= '0;
            r_bit_s1 <= 1'b0;
            r_bit_s  <= 1'b0;
            r_key_s1 <= 1'b0;
            r_key_s  <= 1'b0;
            r_key_q  <= 1'b0;
            r_step   <= 1'b0;
            r_step_q <= 1'b0;
            r_clr    <= 1'b0;
            r_bit    <= 1'b0;
            r_led    <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_bit_s1 <= i_bit_in;
            r_bit_s  <= r_bit_s1;
            r_key_s1 <= i_step_key;
            r_key_s  <= r_key_s1;
            r_key_q  <= r_key_s;
            r_state  <= w_state_nxt;
            r_presc  <= w_presc_nxt;
            r_hold   <= w_hold_nxt;
            r_cnt    <= w_cnt_nxt;
            r_step   <= w_step_nxt;
            r_step_q <= r_step & ~i_clear;
            r_clr    <= w_clr_nxt;
            if (w_step_nxt) r_bit <= r_bit_s;
            r_led    <= w_hold_nxt != '0;
            r_halted <= w_state_nxt == HALT;
        end
    end

    assign o_det_step  = r_step;
    assign o_det_bit   = r_bit;
    assign o_det_clr   = r_clr;
    assign o_match_cnt = r_cnt;
    assign o_match_led = r_led;
    assign o_halted    = r_halted;
    assign o_state_out = r_state;
endmodule
